// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared constants and FSM encoding for the register-file dump reader
//
// Purpose: register-file geometry and the dump FSM state type, shared by the
// reader and anything that needs to decode its state.
// Ports: none (package).
package regfile_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range through one read port and streams (addr, data) beats
//
// Purpose: on an accepted start, reads registers first_addr..last_addr (inclusive)
// one at a time through the shared register-file read port and presents each
// (address, data) pair on a valid/ready output.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, first_addr, last_addr dump request and inclusive range (sampled in IDLE)
//   abort                       cancel a dump in progress
//   rd_addr / rd_data           register-file read port (combinational data)
//   out_valid/out_ready/out_addr/out_data/out_last  beat stream
//   busy                        block owns the read port
//   done, range_err             completion / rejected-start pulses
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;
  logic              range_err_q;

  // The read port only carries cur while the data is being captured; otherwise
  // it idles at 0 so the datapath mux sees a quiet address.
  assign rd_addr   = (state_q == S_READ) ? cur_q : '0;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign range_err = range_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Cancel wins over any handshake in the same cycle.
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (first_addr <= last_addr) begin
                cur_q   <= first_addr;
                last_q  <= last_addr;
                busy_q  <= 1'b1;
                state_q <= S_READ;
              end else begin
                range_err_q <= 1'b1;
              end
            end
          end
          S_READ: begin
            // Snapshot: later register writes cannot disturb a held beat.
            out_data_q  <= rd_data;
            out_addr_q  <= cur_q;
            out_last_q  <= (cur_q == last_q);
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
          S_HOLD: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (out_last_q) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                // cur < last here, so the increment never wraps.
                cur_q   <= cur_q + 1'b1;
                state_q <= S_READ;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
